// File: rtl/ysyx_22040237_mc_core_ctrl_if.sv
// Fetch and data-memory handshake bundle between the multi-cycle core controller and its memories.
// The core drives requests and the fetch address; the memories answer with valid/done strobes.
interface ysyx_22040237_mc_core_ctrl_if #(
    parameter int XLEN = 64
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_rvalid;
    logic [31:0]     if_rdata;
    logic            dm_req;
    logic            dm_done;
    logic            dm_err;

    modport master (
        output if_req, if_addr, dm_req,
        input  if_rvalid, if_rdata, dm_done, dm_err
    );

    modport slave (
        input  if_req, if_addr, dm_req,
        output if_rvalid, if_rdata, dm_done, dm_err
    );
endinterface

// File: rtl/ysyx_22040237_mc_core_ctrl.sv
// Multi-cycle sequencer: owns PC and IR, sequences fetch/exec/mem/writeback, and parks in HALT or
// TRAP until reset. Every output is either a flop or a decode of the state register.
module ysyx_22040237_mc_core_ctrl #(
    parameter int          XLEN          = 64,
    parameter logic [63:0] RESET_PC      = 64'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22040237_mc_core_ctrl_if.master bus,
    output logic [31:0]                  ir,
    output logic                         ir_valid,
    input  logic                         dec_invalid,
    input  logic                         dec_ebreak,
    input  logic                         dec_mem,
    input  logic                         dec_jump,
    input  logic [XLEN-1:0]              dec_jump_addr,
    output logic                         wb_en,
    output logic [XLEN-1:0]              pc,
    output logic                         halted,
    output logic                         trap,
    output logic [2:0]                   trap_cause,
    output logic [63:0]                  retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        C_NONE, C_INVALID, C_MISALIGN, C_DM_ERR, C_TIMEOUT
    } cause_e;

    localparam int              TW       = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(FETCH_TIMEOUT - 1);
    localparam logic [XLEN-1:0] BOOT_PC  = RESET_PC[XLEN-1:0];

    state_e          state_q, state_d;
    cause_e          cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            halted_q, halted_d;
    logic            trap_q, trap_d;
    logic [63:0]     retire_q, retire_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        trap_d   = trap_q;
        retire_d = retire_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                tmo_d   = '0;
            end
            S_FETCH: begin
                // A valid beat in the final allowed cycle still completes the fetch.
                if (bus.if_rvalid) begin
                    ir_d    = bus.if_rdata;
                    state_d = S_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = C_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EXEC: begin
                if (dec_invalid) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = C_INVALID;
                end else if (dec_ebreak) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    retire_d = retire_q + 64'd1;
                end else if (dec_jump && (dec_jump_addr[1:0] != 2'b00)) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = C_MISALIGN;
                end else if (dec_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dm_done) begin
                    if (bus.dm_err) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = C_DM_ERR;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d     = dec_jump ? dec_jump_addr : pc_q + XLEN'(4);
                retire_d = retire_q + 64'd1;
                tmo_d    = '0;
                state_d  = S_FETCH;
            end
            default: ; // HALT and TRAP only leave through reset
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cause_q  <= C_NONE;
            pc_q     <= BOOT_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
            retire_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
            retire_q <= retire_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.if_req  = (state_q == S_FETCH);
    assign bus.if_addr = pc_q;
    assign bus.dm_req  = (state_q == S_MEM);
    assign ir_valid    = (state_q == S_EXEC);
    assign wb_en       = (state_q == S_WB);
    assign ir          = ir_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_ysyx_22040237_mc_core_ctrl.sv
// Bench for the multi-cycle controller: directed scenarios then random instruction streams, each
// instruction checked cycle by cycle against an instruction-level model of PC, retire count and traps.
module tb_ysyx_22040237_mc_core_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          TMO    = 6;

    typedef enum int {
        K_ALU, K_JUMP, K_BADJUMP, K_MEM, K_MEMERR, K_INVALID, K_EBREAK, K_TIMEOUT, K_MEMRST
    } kind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir;
    logic        ir_valid;
    logic        dec_invalid = 1'b0, dec_ebreak = 1'b0, dec_mem = 1'b0, dec_jump = 1'b0;
    logic [63:0] dec_jump_addr = '0;
    logic        wb_en, halted, trap;
    logic [63:0] pc;
    logic [2:0]  trap_cause;
    logic [63:0] retire_cnt;

    logic [31:0] ir32, pc32;
    logic        ir_valid32, wb_en32, halted32, trap32;
    logic [2:0]  cause32;
    logic [63:0] retire32;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] mpc;
    logic [63:0] mret;

    always #5 clk = ~clk;

    ysyx_22040237_mc_core_ctrl_if #(.XLEN(64)) bus   ();
    ysyx_22040237_mc_core_ctrl_if #(.XLEN(32)) bus32 ();

    assign bus32.if_rvalid = 1'b1;
    assign bus32.if_rdata  = 32'h0000_0013;
    assign bus32.dm_done   = 1'b0;
    assign bus32.dm_err    = 1'b0;

    ysyx_22040237_mc_core_ctrl #(.XLEN(64), .RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .dec_invalid   (dec_invalid),
        .dec_ebreak    (dec_ebreak),
        .dec_mem       (dec_mem),
        .dec_jump      (dec_jump),
        .dec_jump_addr (dec_jump_addr),
        .wb_en         (wb_en),
        .pc            (pc),
        .halted        (halted),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .retire_cnt    (retire_cnt)
    );

    ysyx_22040237_mc_core_ctrl #(.XLEN(32), .RESET_PC(64'hFFFF_FFF8), .FETCH_TIMEOUT(4)) dut32 (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus32),
        .ir            (ir32),
        .ir_valid      (ir_valid32),
        .dec_invalid   (1'b0),
        .dec_ebreak    (1'b0),
        .dec_mem       (1'b0),
        .dec_jump      (1'b0),
        .dec_jump_addr (32'h0),
        .wb_en         (wb_en32),
        .pc            (pc32),
        .halted        (halted32),
        .trap          (trap32),
        .trap_cause    (cause32),
        .retire_cnt    (retire32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_done   = 1'b0;
        bus.dm_err    = 1'b0;
        dec_invalid   = 1'b0;
        dec_ebreak    = 1'b0;
        dec_mem       = 1'b0;
        dec_jump      = 1'b0;
        dec_jump_addr = '0;
    endtask

    // Leaves the bench in the first FETCH cycle after reset with the model at boot values.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        #3;
        check("rst_if_req", bus.if_req, 0);
        check("rst_dm_req", bus.dm_req, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_ir", ir, 0);
        check("rst_flags", {halted, trap, trap_cause}, 0);
        check("rst_retire", retire_cnt, 0);
        step();
        rst = 1'b0;
        #3;
        check("idle_if_req", bus.if_req, 0);
        step();
        mpc  = RST_PC;
        mret = 0;
    endtask

    // Absorbing state: nothing moves, whatever the memories do.
    task automatic expect_dead(input logic is_halt, input logic [2:0] cause, input int n);
        for (int i = 0; i < n; i++) begin
            bus.if_rvalid = 1'($urandom);
            bus.dm_done   = 1'($urandom);
            bus.dm_err    = 1'($urandom);
            #3;
            check("dead_if_req", bus.if_req, 0);
            check("dead_dm_req", bus.dm_req, 0);
            check("dead_wb_en", wb_en, 0);
            check("dead_ir_valid", ir_valid, 0);
            check("dead_pc", pc, mpc);
            check("dead_retire", retire_cnt, mret);
            check("dead_halted", halted, is_halt);
            check("dead_trap", trap, !is_halt);
            check("dead_cause", trap_cause, is_halt ? 3'd0 : cause);
            step();
        end
        do_reset();
    endtask

    task automatic run_instr(input kind_e kind, input int fw, input int mw, input logic [63:0] target);
        logic [31:0] word;
        int          limit;
        word  = $urandom;
        limit = (kind == K_TIMEOUT) ? TMO : fw + 1;
        for (int k = 0; k < limit; k++) begin
            bus.if_rvalid = (kind != K_TIMEOUT) && (k == fw);
            bus.if_rdata  = (k == fw) ? word : 32'($urandom);
            #3;
            if (k == 0) begin
                check("fetch_pc", pc, mpc);
                check("fetch_retire", retire_cnt, mret);
            end
            check("fetch_if_req", bus.if_req, 1);
            check("fetch_if_addr", bus.if_addr, mpc);
            check("fetch_wb_en", wb_en, 0);
            check("fetch_ir_valid", ir_valid, 0);
            step();
        end
        bus.if_rvalid = 1'b0;
        if (kind == K_TIMEOUT) begin
            expect_dead(1'b0, 3'd4, 5);
            return;
        end

        dec_invalid   = (kind == K_INVALID);
        dec_ebreak    = (kind == K_EBREAK) || (kind == K_INVALID);
        dec_jump      = (kind == K_JUMP) || (kind == K_BADJUMP);
        dec_mem       = (kind == K_MEM) || (kind == K_MEMERR) || (kind == K_MEMRST) ||
                        (kind == K_EBREAK) || (kind == K_BADJUMP);
        dec_jump_addr = target;
        #3;
        check("exec_ir_valid", ir_valid, 1);
        check("exec_ir", ir, word);
        check("exec_if_req", bus.if_req, 0);
        check("exec_wb_en", wb_en, 0);
        step();

        if (kind == K_INVALID) begin
            expect_dead(1'b0, 3'd1, 5);
            return;
        end
        if (kind == K_EBREAK) begin
            mret++;
            expect_dead(1'b1, 3'd0, 20);
            return;
        end
        if (kind == K_BADJUMP) begin
            expect_dead(1'b0, 3'd2, 5);
            return;
        end
        if (dec_mem) begin
            for (int k = 0; k <= mw; k++) begin
                bus.dm_done = (k == mw);
                bus.dm_err  = (k == mw) ? (kind == K_MEMERR) : 1'($urandom);
                #3;
                check("mem_dm_req", bus.dm_req, 1);
                check("mem_wb_en", wb_en, 0);
                if (kind == K_MEMRST && k == 1) begin
                    #2 rst = 1'b1;
                    #1;
                    check("arst_dm_req", bus.dm_req, 0);
                    check("arst_pc", pc, RST_PC);
                    check("arst_retire", retire_cnt, 0);
                    do_reset();
                    return;
                end
                step();
            end
            bus.dm_done = 1'b0;
            bus.dm_err  = 1'b0;
            if (kind == K_MEMERR) begin
                expect_dead(1'b0, 3'd3, 5);
                return;
            end
        end

        #3;
        check("wb_wb_en", wb_en, 1);
        check("wb_if_req", bus.if_req, 0);
        check("wb_dm_req", bus.dm_req, 0);
        step();
        mpc  = dec_jump ? target : mpc + 64'd4;
        mret = mret + 64'd1;
        clear_inputs();
    endtask

    initial begin
        logic [63:0] exp32;
        logic [63:0] tgt;
        kind_e       kind;
        int          pick;

        clear_inputs();

        // Boot with zero-wait fetches; the 32-bit instance runs in lockstep and wraps its PC.
        do_reset();
        exp32 = 64'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            check("pc32_seq", {32'h0, pc32}, exp32);
            exp32 = (exp32 + 64'd4) & 64'hFFFF_FFFF;
            if (i < 3) run_instr(K_ALU, 0, 0, 64'h3);
        end
        check("boot_retire", retire_cnt, 3);

        // Fetch wait states up to the last cycle before timeout; rvalid must win at the limit.
        run_instr(K_ALU, 5, 0, 64'h0);
        run_instr(K_ALU, TMO - 1, 0, 64'h0);

        run_instr(K_JUMP, 1, 0, 64'h8000_0100);
        check("jump_pc", pc, 64'h8000_0100);
        run_instr(K_BADJUMP, 0, 0, 64'h8000_0102);

        run_instr(K_MEM, 0, 2, 64'h0);
        run_instr(K_MEMERR, 0, 1, 64'h0);
        run_instr(K_EBREAK, 0, 0, 64'h0);
        run_instr(K_INVALID, 0, 0, 64'h0);
        run_instr(K_ALU, 0, 0, 64'h0);
        run_instr(K_TIMEOUT, 0, 0, 64'h0);
        run_instr(K_ALU, 2, 0, 64'h0);
        run_instr(K_MEMRST, 0, 4, 64'h0);
        run_instr(K_ALU, 0, 0, 64'h0);

        // Random instruction stream; terminal kinds reset the core and the model together.
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 15);
            if (pick < 6)        kind = K_ALU;
            else if (pick < 8)   kind = K_JUMP;
            else if (pick < 11)  kind = K_MEM;
            else if (pick == 11) kind = K_MEMERR;
            else if (pick == 12) kind = K_BADJUMP;
            else if (pick == 13) kind = K_INVALID;
            else if (pick == 14) kind = K_EBREAK;
            else                 kind = K_TIMEOUT;
            tgt = {32'($urandom), 32'($urandom)};
            if (kind == K_JUMP)    tgt[1:0] = 2'b00;
            if (kind == K_BADJUMP) tgt[1:0] = 2'($urandom_range(1, 3));
            run_instr(kind, $urandom_range(0, TMO - 1), $urandom_range(0, 3), tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
